// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment readback monitor: active-low segment
// codes (bit 0 = segment a, bit 6 = segment g) and the capture FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SCAN   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational inverse of the hex-to-7-segment encoder. Unknown patterns,
// including a blank digit, map to nibble 0 with the error flag raised.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_err
);

  // Pattern lookup; anything outside the 16 legal codes is an error.
  always_comb begin
    o_nibble = 4'h0;
    o_err    = 1'b0;
    case (i_seg)
      SEG_0:     o_nibble = 4'h0;
      SEG_1:     o_nibble = 4'h1;
      SEG_2:     o_nibble = 4'h2;
      SEG_3:     o_nibble = 4'h3;
      SEG_4:     o_nibble = 4'h4;
      SEG_5:     o_nibble = 4'h5;
      SEG_6:     o_nibble = 4'h6;
      SEG_7:     o_nibble = 4'h7;
      SEG_8:     o_nibble = 4'h8;
      SEG_9:     o_nibble = 4'h9;
      SEG_A:     o_nibble = 4'hA;
      SEG_B:     o_nibble = 4'hB;
      SEG_C:     o_nibble = 4'hC;
      SEG_D:     o_nibble = 4'hD;
      SEG_E:     o_nibble = 4'hE;
      SEG_F:     o_nibble = 4'hF;
      SEG_BLANK: o_err    = 1'b1;
      default:   o_err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Readback monitor for the HEX display bus: waits for the bus to settle,
// decodes one digit per cycle from a frozen snapshot, then hands off the word.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7*NUM_DIGITS-1:0] i_seg_in,
  input  logic                    i_sample_req,
  output logic                    o_busy,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic [NUM_DIGITS-1:0]   o_digit_err,
  output logic                    o_timeout
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  state_e                    r_state;
  logic [7*NUM_DIGITS-1:0]   r_snap;
  logic [STAB_W-1:0]         r_stab_cnt;
  logic [TO_W-1:0]           r_to_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_busy;
  logic                      r_valid;
  logic [4*NUM_DIGITS-1:0]   r_value;
  logic [NUM_DIGITS-1:0]     r_digit_err;
  logic                      r_timeout;

  logic [6:0]                w_digit_seg;
  logic [3:0]                w_nibble;
  logic                      w_err;
  logic                      w_same;

  assign w_same      = (i_seg_in == r_snap);
  assign w_digit_seg = r_snap[7*int'(r_idx) +: 7];

  seg7_to_hex u_dec (
    .i_seg    (w_digit_seg),
    .o_nibble (w_nibble),
    .o_err    (w_err)
  );

  // Capture FSM with counters, snapshot and registered result.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_snap      <= '0;
      r_stab_cnt  <= '0;
      r_to_cnt    <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_value     <= '0;
      r_digit_err <= '0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_sample_req) begin
            r_snap      <= i_seg_in;
            r_stab_cnt  <= '0;
            r_to_cnt    <= '0;
            r_value     <= '0;
            r_digit_err <= '0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // Stability takes priority over a coincident timeout.
          if (w_same && (r_stab_cnt == STAB_LAST)) begin
            r_idx   <= '0;
            r_state <= ST_SCAN;
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout   <= 1'b1;
            r_value     <= '0;
            r_digit_err <= '1;
            r_busy      <= 1'b0;
            r_valid     <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (w_same) begin
              r_stab_cnt <= r_stab_cnt + 1'b1;
            end else begin
              r_snap     <= i_seg_in;
              r_stab_cnt <= '0;
            end
          end
        end
        ST_SCAN: begin
          r_value[4*int'(r_idx) +: 4] <= w_nibble;
          r_digit_err[r_idx]          <= w_err;
          if (r_idx == IDX_LAST) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_HOLD: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_valid     = r_valid;
  assign o_value     = r_value;
  assign o_digit_err = r_digit_err;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: directed scenarios plus randomized bus
// schedules, each compared against a sample-history reference model.
module tb_seg7_reader;

  localparam int N = 4;
  localparam int S = 4;
  localparam int T = 16;

  logic           clk;
  logic           rst;
  logic [7*N-1:0] seg_in;
  logic           sample_req;
  logic           ready;
  logic           busy;
  logic           valid;
  logic [4*N-1:0] value;
  logic [N-1:0]   digit_err;
  logic           timeout_o;

  int tests = 0;
  int fails = 0;
  int xfers = 0;

  logic [27:0] samp [0:63];
  logic [6:0]  codes [0:15];

  int          exp_edge;
  logic [15:0] exp_val;
  logic [3:0]  exp_err;
  logic        exp_to;

  int          obs_edge;
  logic [15:0] last_val;
  logic [3:0]  last_err;
  logic        last_to;

  seg7_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S), .TIMEOUT(T)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_seg_in     (seg_in),
    .i_sample_req (sample_req),
    .o_busy       (busy),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_value      (value),
    .o_digit_err  (digit_err),
    .o_timeout    (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid && ready) xfers++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] nib, output logic err);
    nib = 4'h0;
    err = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (codes[c] === p) begin
        nib = 4'(c);
        err = 1'b0;
      end
    end
  endfunction

  // Capture begins at the first edge whose sample equals the previous S samples.
  task automatic run_model();
    logic       same;
    logic       found;
    logic [3:0] nb;
    logic       er;
    exp_to   = 1'b1;
    exp_edge = T;
    exp_val  = 16'h0000;
    exp_err  = 4'hF;
    found    = 1'b0;
    for (int e = S; e <= T; e++) begin
      if (!found) begin
        same = 1'b1;
        for (int j = e - S; j < e; j++) begin
          if (samp[j] !== samp[e]) same = 1'b0;
        end
        if (same) begin
          found    = 1'b1;
          exp_to   = 1'b0;
          exp_edge = e + N;
          for (int d = 0; d < N; d++) begin
            ref_decode(samp[e][7*d +: 7], nb, er);
            exp_val[4*d +: 4] = nb;
            exp_err[d]        = er;
          end
        end
      end
    end
  endtask

  task automatic fill(input logic [27:0] v, input int from);
    for (int k = from; k < 64; k++) samp[k] = v;
  endtask

  function automatic logic [27:0] rand_word();
    logic [27:0] w;
    for (int d = 0; d < N; d++) begin
      if ($urandom_range(0, 3) != 0) w[7*d +: 7] = codes[$urandom_range(0, 15)];
      else                           w[7*d +: 7] = 7'($urandom);
    end
    return w;
  endfunction

  task automatic capture(input string tag, input int hold, input logic req_in_hold);
    int xb;
    run_model();
    obs_edge = -1;
    @(negedge clk);
    seg_in     = samp[0];
    sample_req = 1'b1;
    ready      = (hold == 0);
    for (int k = 0; k <= exp_edge; k++) begin
      @(negedge clk);
      sample_req = 1'b0;
      if (valid === 1'b1 && obs_edge < 0) obs_edge = k;
      check({tag, ".valid"}, {31'd0, valid}, {31'd0, (k == exp_edge)});
      check({tag, ".busy"},  {31'd0, busy},  {31'd0, (k != exp_edge)});
      seg_in = samp[k + 1];
    end
    check({tag, ".value"},   {16'd0, value},       {16'd0, exp_val});
    check({tag, ".err"},     {28'd0, digit_err},   {28'd0, exp_err});
    check({tag, ".timeout"}, {31'd0, timeout_o},   {31'd0, exp_to});
    last_val = value;
    last_err = digit_err;
    last_to  = timeout_o;
    xb = xfers;
    for (int h = 0; h < hold; h++) begin
      sample_req = req_in_hold & h[0];
      @(negedge clk);
      check({tag, ".hold_valid"}, {31'd0, valid},     32'd1);
      check({tag, ".hold_value"}, {16'd0, value},     {16'd0, exp_val});
      check({tag, ".hold_err"},   {28'd0, digit_err}, {28'd0, exp_err});
      check({tag, ".hold_busy"},  {31'd0, busy},      32'd0);
    end
    ready      = 1'b1;
    sample_req = req_in_hold;
    @(negedge clk);
    sample_req = 1'b0;
    check({tag, ".drop_valid"}, {31'd0, valid}, 32'd0);
    check({tag, ".xfer_count"}, 32'(xfers),     32'(xb + 1));
    @(negedge clk);
    check({tag, ".idle_busy"},  {31'd0, busy},  32'd0);
  endtask

  logic [27:0] wa, wb, wc, wv;
  logic [15:0] tbl_val;
  int          nchg;
  int          xb_rst;

  initial begin
    codes[0]  = 7'h40; codes[1]  = 7'h79; codes[2]  = 7'h24; codes[3]  = 7'h30;
    codes[4]  = 7'h19; codes[5]  = 7'h12; codes[6]  = 7'h02; codes[7]  = 7'h78;
    codes[8]  = 7'h00; codes[9]  = 7'h18; codes[10] = 7'h08; codes[11] = 7'h03;
    codes[12] = 7'h46; codes[13] = 7'h21; codes[14] = 7'h06; codes[15] = 7'h0E;

    rst        = 1'b0;
    seg_in     = '0;
    sample_req = 1'b0;
    ready      = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst.busy",    {31'd0, busy},      32'd0);
    check("rst.valid",   {31'd0, valid},     32'd0);
    check("rst.value",   {16'd0, value},     32'd0);
    check("rst.err",     {28'd0, digit_err}, 32'd0);
    check("rst.timeout", {31'd0, timeout_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    wa = {7'h79, 7'h24, 7'h30, 7'h19};
    fill(wa, 0);
    capture("static", 0, 1'b0);
    check("static.word",  {16'd0, last_val}, 32'h1234);
    check("static.edge",  32'(obs_edge),     32'd8);

    for (int j = 0; j < 4; j++) begin
      fill({codes[4*j+3], codes[4*j+2], codes[4*j+1], codes[4*j]}, 0);
      capture("table", 0, 1'b0);
      tbl_val = {4'(4*j+3), 4'(4*j+2), 4'(4*j+1), 4'(4*j)};
      check("table.word", {16'd0, last_val}, {16'd0, tbl_val});
      check("table.err",  {28'd0, last_err}, 32'd0);
    end

    fill({7'h7F, 7'h40, 7'h0E, 7'h55}, 0);
    capture("badcode", 0, 1'b0);
    check("badcode.word", {16'd0, last_val}, 32'h00F0);
    check("badcode.err",  {28'd0, last_err}, 32'h9);

    wb = {7'h00, 7'h08, 7'h46, 7'h21};
    wc = {7'h06, 7'h0E, 7'h03, 7'h18};
    fill(wa, 0);
    fill(wb, 2);
    fill(wc, 5);
    capture("toggle", 0, 1'b0);
    check("toggle.edge", 32'(obs_edge),     32'd13);
    check("toggle.word", {16'd0, last_val}, 32'hEFB9);

    for (int k = 0; k < 64; k++) samp[k] = k[0] ? wb : wa;
    capture("tmo", 0, 1'b0);
    check("tmo.edge",  32'(obs_edge),     32'd16);
    check("tmo.flag",  {31'd0, last_to},  32'd1);
    check("tmo.word",  {16'd0, last_val}, 32'd0);
    check("tmo.err",   {28'd0, last_err}, 32'hF);

    fill(wc, 0);
    capture("bp", 10, 1'b1);

    for (int r = 0; r < 12; r++) begin
      wv = rand_word();
      fill(wv, 0);
      nchg = $urandom_range(0, 3);
      for (int c = 0; c < nchg; c++) begin
        wv = rand_word();
        fill(wv, $urandom_range(1, 14));
      end
      if ($urandom_range(0, 3) == 0) samp[$urandom_range(1, 16)] = rand_word();
      capture("rand", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    fill(wa, 0);
    @(negedge clk);
    seg_in     = wa;
    sample_req = 1'b1;
    ready      = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    repeat (5) @(negedge clk);
    check("rstscan.busy_before", {31'd0, busy}, 32'd1);
    xb_rst = xfers;
    #2 rst = 1'b1;
    #1;
    check("rstscan.busy",    {31'd0, busy},      32'd0);
    check("rstscan.valid",   {31'd0, valid},     32'd0);
    check("rstscan.value",   {16'd0, value},     32'd0);
    check("rstscan.err",     {28'd0, digit_err}, 32'd0);
    check("rstscan.timeout", {31'd0, timeout_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("rstscan.quiet_valid", {31'd0, valid}, 32'd0);
      check("rstscan.quiet_busy",  {31'd0, busy},  32'd0);
    end
    check("rstscan.xfers", 32'(xfers), 32'(xb_rst));

    fill(wb, 0);
    capture("recover", 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
